tmds_encoder: RTL and testbench



---
 rtl/tmds_encoder.sv | 121 ++++++++++++
 tb/tb_tmds_encoder.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_encoder.sv
// One DVI TMDS channel: 8b/10b transition-minimised, DC-balanced encoder.
// Two-stage pipeline: stage 1 picks XOR/XNOR chaining, stage 2 balances disparity.
module tmds_encoder #(
  parameter bit OUT_INVERT = 1'b0
) (
  input  logic       clk_pixel,
  input  logic       async_reset,
  input  logic [7:0] data,
  input  logic [1:0] c,
  input  logic       blank,
  output logic [9:0] tmds_out
);

  localparam int unsigned DW = 8;
  localparam int unsigned QW = 9;
  localparam int unsigned SW = 10;
  localparam int unsigned CW = 5;
  localparam int unsigned AW = 6;
  localparam int unsigned NW = 4;

  localparam logic [SW-1:0] CTRL_00  = 10'b1101010100;
  localparam logic [SW-1:0] CTRL_01  = 10'b0010101011;
  localparam logic [SW-1:0] CTRL_10  = 10'b0101010100;
  localparam logic [SW-1:0] CTRL_11  = 10'b1010101011;
  localparam logic [SW-1:0] INV_MASK = {SW{OUT_INVERT}};

  logic [NW-1:0]        n1d;
  logic                 use_xnor;
  logic [QW-1:0]        q_m_c;
  logic [QW-1:0]        q_m;
  logic                 blank_d;
  logic [1:0]           c_d;

  logic [NW-1:0]        n1;
  logic signed [AW-1:0] bal;
  logic signed [AW-1:0] cnt_ext;
  logic                 ones_heavy;
  logic [SW-1:0]        ctrl_sym;
  logic [SW-1:0]        sym_c;
  logic signed [AW-1:0] cnt_next_c;
  logic [CW-1:0]        cnt;

  // Stage 1: count input ones and build the transition-minimised word
  always_comb begin
    n1d = '0;
    for (int i = 0; i < DW; i++) begin
      n1d = n1d + NW'(data[i]);
    end
    use_xnor = (n1d > NW'(4)) || ((n1d == NW'(4)) && !data[0]);
    q_m_c    = '0;
    q_m_c[0] = data[0];
    for (int i = 1; i < DW; i++) begin
      q_m_c[i] = use_xnor ? ~(q_m_c[i-1] ^ data[i]) : (q_m_c[i-1] ^ data[i]);
    end
    q_m_c[DW] = ~use_xnor;
  end

  always_ff @(posedge clk_pixel or posedge async_reset) begin
    if (async_reset) begin
      q_m     <= '0;
      blank_d <= 1'b1;
      c_d     <= 2'b00;
    end else begin
      q_m     <= q_m_c;
      blank_d <= blank;
      c_d     <= c;
    end
  end

  // Stage 2: balance is n1 - n0 = 2*n1 - 8, kept one bit wider than cnt
  always_comb begin
    n1 = '0;
    for (int i = 0; i < DW; i++) begin
      n1 = n1 + NW'(q_m[i]);
    end
  end

  assign bal        = AW'({n1, 1'b0}) - AW'(8);
  assign cnt_ext    = {cnt[CW-1], cnt};
  assign ones_heavy = (!cnt[CW-1] && (bal > 6'sd0)) || (cnt[CW-1] && (bal < 6'sd0));

  always_comb begin
    ctrl_sym = CTRL_00;
    case (c_d)
      2'b00:   ctrl_sym = CTRL_00;
      2'b01:   ctrl_sym = CTRL_01;
      2'b10:   ctrl_sym = CTRL_10;
      default: ctrl_sym = CTRL_11;
    endcase
  end

  always_comb begin
    sym_c      = CTRL_00;
    cnt_next_c = '0;
    if (blank_d) begin
      sym_c      = ctrl_sym;
      cnt_next_c = '0;
    end else if ((cnt == '0) || (bal == '0)) begin
      sym_c      = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
      cnt_next_c = q_m[8] ? (cnt_ext + bal) : (cnt_ext - bal);
    end else if (ones_heavy) begin
      sym_c      = {1'b1, q_m[8], ~q_m[7:0]};
      cnt_next_c = cnt_ext + (q_m[8] ? AW'(2) : AW'(0)) - bal;
    end else begin
      sym_c      = {1'b0, q_m[8], q_m[7:0]};
      cnt_next_c = cnt_ext - (q_m[8] ? AW'(0) : AW'(2)) + bal;
    end
  end

  // Inversion folded into the output register keeps latency identical
  always_ff @(posedge clk_pixel or posedge async_reset) begin
    if (async_reset) begin
      tmds_out <= CTRL_00 ^ INV_MASK;
      cnt      <= '0;
    end else begin
      tmds_out <= sym_c ^ INV_MASK;
      cnt      <= cnt_next_c[CW-1:0];
    end
  end

endmodule

// File: tb/tb_tmds_encoder.sv
// Directed and model-checked bench for one TMDS encoder channel plus an inverted twin.
module tb_tmds_encoder;

  logic       clk_pixel = 1'b0;
  logic       async_reset;
  logic [7:0] data;
  logic [1:0] c;
  logic       blank;
  logic [9:0] tmds_out;
  logic [9:0] tmds_out_inv;

  int checks   = 0;
  int failures = 0;

  localparam logic [9:0] C00 = 10'b1101010100;
  localparam logic [9:0] C01 = 10'b0010101011;
  localparam logic [9:0] C10 = 10'b0101010100;
  localparam logic [9:0] C11 = 10'b1010101011;
  localparam logic [9:0] S00 = 10'b0100000000;
  localparam logic [9:0] S11 = 10'b1111111111;
  localparam logic [9:0] SFF = 10'b1000000000;

  tmds_encoder #(.OUT_INVERT(1'b0)) dut (
    .clk_pixel(clk_pixel), .async_reset(async_reset), .data(data),
    .c(c), .blank(blank), .tmds_out(tmds_out)
  );

  tmds_encoder #(.OUT_INVERT(1'b1)) dut_inv (
    .clk_pixel(clk_pixel), .async_reset(async_reset), .data(data),
    .c(c), .blank(blank), .tmds_out(tmds_out_inv)
  );

  always #5 clk_pixel = ~clk_pixel;

  // Inputs change on the falling edge; the symbol for tick k is visible after tick k+2
  task automatic tick(input logic [7:0] d, input logic [1:0] cc, input logic b);
    @(negedge clk_pixel);
    data  = d;
    c     = cc;
    blank = b;
    #1;
  endtask

  task automatic model_step(input logic [7:0] d, input logic [1:0] cc, input logic b,
                            input int cnt_in, output logic [9:0] sym, output int cnt_out);
    int ones, n1, n0;
    logic xn;
    logic [8:0] qm;
    if (b) begin
      cnt_out = 0;
      case (cc)
        2'b00: sym = C00;
        2'b01: sym = C01;
        2'b10: sym = C10;
        default: sym = C11;
      endcase
    end else begin
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
      xn = (ones > 4) || (ones == 4 && d[0] == 1'b0);
      qm = '0;
      qm[0] = d[0];
      for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
      qm[8] = ~xn;
      n1 = 0;
      for (int i = 0; i < 8; i++) n1 += int'(qm[i]);
      n0 = 8 - n1;
      if (cnt_in == 0 || n1 == n0) begin
        sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
        cnt_out = cnt_in + (qm[8] ? (n1 - n0) : (n0 - n1));
      end else if ((cnt_in > 0 && n1 > n0) || (cnt_in < 0 && n0 > n1)) begin
        sym = {1'b1, qm[8], ~qm[7:0]};
        cnt_out = cnt_in + (qm[8] ? 2 : 0) + (n0 - n1);
      end else begin
        sym = {1'b0, qm[8], qm[7:0]};
        cnt_out = cnt_in - (qm[8] ? 0 : 2) + (n1 - n0);
      end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (tmds_out !== C00) begin
      failures++;
      $display("FAIL reset_out: got %b expected %b", tmds_out, C00);
    end
    checks++;
    if (tmds_out_inv !== ~C00) begin
      failures++;
      $display("FAIL reset_out_inv: got %b expected %b", tmds_out_inv, ~C00);
    end
    checks++;
    if (dut.cnt !== 5'd0) begin
      failures++;
      $display("FAIL reset_cnt: got %0d expected 0", $signed(dut.cnt));
    end
    @(negedge clk_pixel);
    async_reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(8'h00, 2'b00, 1'b1);
      checks++;
      if (tmds_out !== C00) begin
        failures++;
        $display("FAIL idle_out[%0d]: got %b expected %b", i, tmds_out, C00);
      end
    end
  endtask

  task automatic test_control();
    logic [9:0] exp_ctrl [4] = '{C00, C01, C10, C11};
    for (int i = 0; i < 6; i++) begin
      tick(8'h5A, (i < 4) ? 2'(i) : 2'b00, 1'b1);
      if (i >= 2) begin
        checks++;
        if (tmds_out !== exp_ctrl[i-2]) begin
          failures++;
          $display("FAIL ctrl_code[%0d]: got %b expected %b", i - 2, tmds_out, exp_ctrl[i-2]);
        end
        checks++;
        if (tmds_out_inv !== ~exp_ctrl[i-2]) begin
          failures++;
          $display("FAIL ctrl_code_inv[%0d]: got %b expected %b", i - 2, tmds_out_inv, ~exp_ctrl[i-2]);
        end
      end
    end
  endtask

  task automatic test_disparity();
    logic [9:0] exp_out [3] = '{S00, S11, S00};
    logic [4:0] exp_cnt [3] = '{5'(-8), 5'd2, 5'(-6)};
    for (int i = 0; i < 5; i++) begin
      tick(8'h00, 2'b00, i >= 3);
      if (i >= 2) begin
        checks++;
        if (tmds_out !== exp_out[i-2]) begin
          failures++;
          $display("FAIL disparity_out[%0d]: got %b expected %b", i - 2, tmds_out, exp_out[i-2]);
        end
        checks++;
        if (dut.cnt !== exp_cnt[i-2]) begin
          failures++;
          $display("FAIL disparity_cnt[%0d]: got %0d expected %0d", i - 2, $signed(dut.cnt), $signed(exp_cnt[i-2]));
        end
      end
    end
  endtask

  task automatic test_xnor();
    tick(8'hFF, 2'b00, 1'b0);
    tick(8'h00, 2'b00, 1'b1);
    tick(8'h00, 2'b00, 1'b1);
    checks++;
    if (tmds_out !== SFF) begin
      failures++;
      $display("FAIL xnor_out: got %b expected %b", tmds_out, SFF);
    end
    checks++;
    if (dut.cnt !== 5'(-8)) begin
      failures++;
      $display("FAIL xnor_cnt: got %0d expected -8", $signed(dut.cnt));
    end
  endtask

  task automatic test_blank_reentry();
    logic       bl      [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [9:0] exp_out [4] = '{S00, S11, C00, S00};
    logic [4:0] exp_cnt [4] = '{5'(-8), 5'd2, 5'd0, 5'(-8)};
    for (int i = 0; i < 6; i++) begin
      tick(8'h00, 2'b00, bl[i]);
      if (i >= 2) begin
        checks++;
        if (tmds_out !== exp_out[i-2]) begin
          failures++;
          $display("FAIL reentry_out[%0d]: got %b expected %b", i - 2, tmds_out, exp_out[i-2]);
        end
        checks++;
        if (dut.cnt !== exp_cnt[i-2]) begin
          failures++;
          $display("FAIL reentry_cnt[%0d]: got %0d expected %0d", i - 2, $signed(dut.cnt), $signed(exp_cnt[i-2]));
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) tick(8'h00, 2'b00, 1'b0);
    #2;
    async_reset = 1'b1;
    #1;
    checks++;
    if (tmds_out !== C00) begin
      failures++;
      $display("FAIL midreset_out: got %b expected %b", tmds_out, C00);
    end
    checks++;
    if (tmds_out_inv !== ~C00) begin
      failures++;
      $display("FAIL midreset_out_inv: got %b expected %b", tmds_out_inv, ~C00);
    end
    checks++;
    if (dut.cnt !== 5'd0) begin
      failures++;
      $display("FAIL midreset_cnt: got %0d expected 0", $signed(dut.cnt));
    end
    tick(8'h00, 2'b00, 1'b1);
    async_reset = 1'b0;
    tick(8'h00, 2'b00, 1'b0);
    checks++;
    if (tmds_out !== C00) begin
      failures++;
      $display("FAIL post_reset_flush: got %b expected %b", tmds_out, C00);
    end
    tick(8'h00, 2'b00, 1'b1);
    tick(8'h00, 2'b00, 1'b1);
    checks++;
    if (tmds_out !== S00) begin
      failures++;
      $display("FAIL post_reset_first: got %b expected %b", tmds_out, S00);
    end
    checks++;
    if (dut.cnt !== 5'(-8)) begin
      failures++;
      $display("FAIL post_reset_cnt: got %0d expected -8", $signed(dut.cnt));
    end
  endtask

  task automatic test_soak();
    localparam int N = 3000;
    logic [9:0] exp_out [N];
    int         exp_cnt [N];
    int         mcnt = 0;
    int         cv;
    logic       b = 1'b1;
    logic [7:0] d;
    logic [1:0] cc;
    for (int k = 0; k < N; k++) begin
      if (k >= 2 && $urandom_range(0, 15) == 0) b = ~b;
      d  = 8'($urandom);
      cc = 2'($urandom);
      tick(d, cc, (k < 2) ? 1'b1 : b);
      model_step(d, cc, (k < 2) ? 1'b1 : b, mcnt, exp_out[k], exp_cnt[k]);
      mcnt = exp_cnt[k];
      if (k >= 2) begin
        checks++;
        if (tmds_out !== exp_out[k-2]) begin
          failures++;
          $display("FAIL soak_out[%0d]: got %b expected %b", k - 2, tmds_out, exp_out[k-2]);
        end
        checks++;
        if (tmds_out_inv !== ~exp_out[k-2]) begin
          failures++;
          $display("FAIL soak_inv[%0d]: got %b expected %b", k - 2, tmds_out_inv, ~exp_out[k-2]);
        end
        checks++;
        if (dut.cnt !== 5'(exp_cnt[k-2])) begin
          failures++;
          $display("FAIL soak_cnt[%0d]: got %0d expected %0d", k - 2, $signed(dut.cnt), exp_cnt[k-2]);
        end
        cv = int'($signed(dut.cnt));
        checks++;
        if (cv > 10 || cv < -10) begin
          failures++;
          $display("FAIL soak_cnt_bound[%0d]: got %0d expected within -10..10", k - 2, cv);
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    async_reset = 1'b1;
    data        = 8'h00;
    c           = 2'b00;
    blank       = 1'b1;
    test_reset();
    test_control();
    test_disparity();
    test_xnor();
    test_blank_reentry();
    test_reset_midstream();
    test_soak();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
